// File: rtl/pixel_fetch_pkg.sv
// Shared types and default VGA timing for the pixel line fetcher and the VGA controller.
// Combinational: no latency, no flow control.
package pixel_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  typedef logic [15:0] fb_word_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOTAL_DEF  = 525;

endpackage

// File: rtl/line_ram.sv
// Ping-pong line buffer: two banks of HALF words, with the bank bit as the address MSB.
// Registered read gives 1-cycle latency; always accepts a write and a read each cycle.
module line_ram
  import pixel_fetch_pkg::*;
#(
  parameter int HALF = 320,
  parameter int IW   = $clog2(HALF)
) (
  input  logic     clk,
  input  logic     we,
  input  logic [IW:0] waddr,
  input  fb_word_t wdata,
  input  logic [IW:0] raddr,
  output fb_word_t rdata
);

  fb_word_t mem [2][HALF];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW]][waddr[IW-1:0]] <= wdata;
    rdata <= mem[raddr[IW]][raddr[IW-1:0]];
  end

endmodule

// File: rtl/pixel_line_fetch.sv
// Prefetches the next raster line into a ping-pong buffer and emits one palette index per pixel clock.
// PIXEL_OUT lags DRAW_X/DRAW_Y by 1 cycle; MEM_REQ is held until MEM_ACK. Option macro: PIXEL_FETCH_TESTPAT_EN.
module pixel_line_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          H_TOTAL  = H_TOTAL_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter int          V_TOTAL  = V_TOTAL_DEF,
  parameter int          ADDR_W   = 20,
  parameter int unsigned FB_BASE  = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DRAW_X,
  input  logic [9:0]        DRAW_Y,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_RDATA,
  output logic [7:0]        PIXEL_OUT,
  output logic              UNDERRUN
`ifdef PIXEL_FETCH_TESTPAT_EN
  ,
  input  logic              TESTPAT
`endif
);

  localparam int HALF = H_ACTIVE / 2;
  localparam int IW   = $clog2(HALF);

  localparam logic [9:0]        X_TRIG    = 10'(H_ACTIVE);
  localparam logic [9:0]        X_SWAP    = 10'(H_TOTAL - 1);
  localparam logic [9:0]        Y_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]        Y_LASTF   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]        Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [IW-1:0]     LAST_WORD = IW'(HALF - 1);
  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(HALF);

  fetch_state_t      state, state_nxt;
  logic [IW-1:0]     word_cnt;
  logic [ADDR_W-1:0] line_base;
  logic              bank_sel;
  logic              trigger, swap, active, last_ack;
  logic              line_end, underrun_set;

  assign trigger  = (DRAW_X == X_TRIG) && ((DRAW_Y < Y_LASTF) || (DRAW_Y == Y_LAST));
  assign swap     = (DRAW_X == X_SWAP);
  assign active   = (DRAW_X < X_TRIG) && (DRAW_Y < Y_ACT);
  assign last_ack = MEM_ACK && (word_cnt == LAST_WORD);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A last-word ack landing on the swap cycle still completes the line, so it is not an underrun.
  always_comb begin
    state_nxt    = state;
    line_end     = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      IDLE: if (trigger) state_nxt = REQ;
      REQ: begin
        if (last_ack) begin
          state_nxt = swap ? IDLE : DONE;
          line_end  = 1'b1;
        end else if (swap) begin
          state_nxt    = IDLE;
          line_end     = 1'b1;
          underrun_set = 1'b1;
        end
      end
      DONE: if (swap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bank_sel  <= 1'b0;
      line_base <= BASE0;
      UNDERRUN  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (swap) bank_sel <= ~bank_sel;
      if (underrun_set) UNDERRUN <= 1'b1;
      if (state == IDLE && trigger) begin
        word_cnt <= '0;
        if (DRAW_Y == Y_LAST) line_base <= BASE0;
      end else if (state == REQ && MEM_ACK) begin
        word_cnt <= word_cnt + IW'(1);
      end
      // Advancing on every line end, even an underrun, keeps later rows aligned without a multiply.
      if (line_end) line_base <= line_base + STRIDE;
    end
  end

  assign MEM_REQ  = (state == REQ);
  assign MEM_ADDR = MEM_REQ ? (line_base + ADDR_W'(word_cnt)) : '0;

  logic          ram_we;
  logic [IW:0]   ram_waddr, ram_raddr;
  fb_word_t      ram_rdata;

  assign ram_we    = (state == REQ) && MEM_ACK;
  assign ram_waddr = {~bank_sel, word_cnt};
  assign ram_raddr = active ? {bank_sel, DRAW_X[IW:1]} : {bank_sel, {IW{1'b0}}};

  line_ram #(
    .HALF (HALF),
    .IW   (IW)
  ) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (MEM_RDATA),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  logic       active_q, byte_q;
  logic [7:0] pix_fb, pix_sel;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_q <= 1'b0;
      byte_q   <= 1'b0;
    end else begin
      active_q <= active;
      byte_q   <= DRAW_X[0];
    end
  end

  assign pix_fb = byte_q ? ram_rdata[15:8] : ram_rdata[7:0];

`ifdef PIXEL_FETCH_TESTPAT_EN
  logic       tp_q;
  logic [7:0] pat_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tp_q  <= 1'b0;
      pat_q <= 8'h00;
    end else begin
      tp_q  <= TESTPAT;
      pat_q <= {DRAW_X[9:7], DRAW_Y[8:6], DRAW_X[6:5]};
    end
  end

  assign pix_sel = tp_q ? pat_q : pix_fb;
`else
  assign pix_sel = pix_fb;
`endif

  assign PIXEL_OUT = active_q ? pix_sel : 8'h00;

endmodule

// File: tb/tb_pixel_line_fetch.sv
// Directed bench for pixel_line_fetch: reset, prefetch, decode, address advance, underrun, reset mid-fetch.
module tb_pixel_line_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DRAW_X, DRAW_Y;
  logic        MEM_REQ;
  logic [19:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic [7:0]  PIXEL_OUT;
  logic        UNDERRUN;
`ifdef PIXEL_FETCH_TESTPAT_EN
  logic        TESTPAT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  pixel_line_fetch dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DRAW_X    (DRAW_X),
    .DRAW_Y    (DRAW_Y),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_ACK   (MEM_ACK),
    .MEM_RDATA (MEM_RDATA),
    .PIXEL_OUT (PIXEL_OUT),
    .UNDERRUN  (UNDERRUN)
`ifdef PIXEL_FETCH_TESTPAT_EN
    ,
    .TESTPAT   (TESTPAT)
`endif
  );

  always #20 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] exp, input string tag);
    DRAW_X = 10'(x);
    DRAW_Y = 10'(y);
    tick();
    chk(tag, 32'(PIXEL_OUT), 32'(exp));
  endtask

  int nacks;

  initial begin
    Reset = 1'b1; DRAW_X = 10'd640; DRAW_Y = 10'd524; MEM_ACK = 1'b0; MEM_RDATA = 16'h0;

    // Reset held for 3 cycles, with a trigger position presented
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_req", 32'(MEM_REQ), 32'd0);
      chk("rst_pix", 32'(PIXEL_OUT), 32'd0);
      chk("rst_ur",  32'(UNDERRUN), 32'd0);
    end
    chk("rst_addr", 32'(MEM_ADDR), 32'd0);

    // Row-0 prefetch into bank 1, ack tied high
    Reset = 1'b0;
    tick();
    chk("r0_req_rise", 32'(MEM_REQ), 32'd1);
    DRAW_X = 10'd700;
    MEM_ACK = 1'b1;
    for (int i = 0; i < 320; i++) begin
      MEM_RDATA = (i == 0) ? 16'hE31C : {8'(i) + 8'h40, 8'(i)};
      chk("r0_addr", 32'(MEM_ADDR), 32'(i));
      if (i == 319) chk("r0_req_last", 32'(MEM_REQ), 32'd1);
      tick();
    end
    MEM_ACK = 1'b0;
    chk("r0_req_drop", 32'(MEM_REQ), 32'd0);
    chk("r0_no_ur", 32'(UNDERRUN), 32'd0);

    // Swap, then decode row 0 with 1-cycle latency
    DRAW_X = 10'd799;
    tick();
    pix(0,   0,   8'h1C, "pix_0_0");
    pix(1,   0,   8'hE3, "pix_1_0");
    pix(2,   0,   8'h01, "pix_2_0");
    pix(3,   0,   8'h41, "pix_3_0");
    pix(638, 0,   8'h3F, "pix_638_0");
    pix(639, 0,   8'h7F, "pix_639_0");
    pix(700, 0,   8'h00, "pix_hblank");
    pix(5,   480, 8'h00, "pix_vblank");

    // Row 1 fetch starts one line stride on and fills bank 0
    DRAW_X = 10'd640; DRAW_Y = 10'd0;
    tick();
    chk("r1_req", 32'(MEM_REQ), 32'd1);
    chk("r1_addr", 32'(MEM_ADDR), 32'd320);
    DRAW_X = 10'd700;
    MEM_ACK = 1'b1;
    for (int i = 0; i < 320; i++) begin
      MEM_RDATA = 16'hB010 + 16'(i);
      tick();
    end
    MEM_ACK = 1'b0;
    chk("r1_req_drop", 32'(MEM_REQ), 32'd0);
    DRAW_X = 10'd799;
    tick();
    pix(0, 1, 8'h10, "pix_0_1");
    pix(1, 1, 8'hB0, "pix_1_1");

    // Row 2 fetch begins at FB_BASE+640
    DRAW_X = 10'd640; DRAW_Y = 10'd1;
    tick();
    chk("r2_req", 32'(MEM_REQ), 32'd1);
    chk("r2_addr", 32'(MEM_ADDR), 32'd640);

    // Ack every 4th cycle while the raster runs to the swap
    nacks = 0;
    MEM_RDATA = 16'h5555;
    for (int x = 641; x <= 799; x++) begin
      DRAW_X = 10'(x);
      MEM_ACK = (((x - 641) % 4) == 3);
      if (x == 799) begin
        chk("ur_addr_pre", 32'(MEM_ADDR), 32'(640 + nacks));
        chk("ur_pre", 32'(UNDERRUN), 32'd0);
      end
      tick();
      if (MEM_ACK) nacks++;
    end
    MEM_ACK = 1'b0;
    chk("ur_set", 32'(UNDERRUN), 32'd1);
    chk("ur_req_drop", 32'(MEM_REQ), 32'd0);

    // Ack while idle is ignored
    DRAW_X = 10'd700; MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    chk("idle_ack", 32'(MEM_REQ), 32'd0);

    // No fetch triggered from rows 479..523
    DRAW_X = 10'd640; DRAW_Y = 10'd479;
    tick();
    chk("nofetch_479", 32'(MEM_REQ), 32'd0);
    DRAW_Y = 10'd500;
    tick();
    chk("nofetch_500", 32'(MEM_REQ), 32'd0);
    DRAW_Y = 10'd523;
    tick();
    chk("nofetch_523", 32'(MEM_REQ), 32'd0);
    chk("ur_sticky", 32'(UNDERRUN), 32'd1);

    // Reset at word 100 of a fetch into bank 0 (base advanced past the underrun line)
    DRAW_X = 10'd640; DRAW_Y = 10'd10;
    tick();
    chk("rf_addr0", 32'(MEM_ADDR), 32'd960);
    DRAW_X = 10'd700;
    MEM_ACK = 1'b1;
    for (int i = 0; i < 100; i++) begin
      MEM_RDATA = 16'h7700 + 16'(i);
      tick();
    end
    MEM_ACK = 1'b0;
    chk("rf_addr100", 32'(MEM_ADDR), 32'd1060);
    Reset = 1'b1;
    tick();
    chk("rf_req", 32'(MEM_REQ), 32'd0);
    chk("rf_addr", 32'(MEM_ADDR), 32'd0);
    chk("rf_ur_clr", 32'(UNDERRUN), 32'd0);
    chk("rf_pix", 32'(PIXEL_OUT), 32'd0);
    Reset = 1'b0;
    tick();
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD;
    tick();
    MEM_ACK = 1'b0;
    chk("rf_late_ack", 32'(MEM_REQ), 32'd0);

    // Bank 0 is displayed after reset: words 0..99 new, word 100 still row 1
    pix(0,   5, 8'h00, "rf_pix_0");
    pix(1,   5, 8'h77, "rf_pix_1");
    pix(198, 5, 8'h63, "rf_pix_198");
    pix(200, 5, 8'h74, "rf_pix_200");
    pix(201, 5, 8'hB0, "rf_pix_201");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
